// File: rtl/guess_game_n.sv
// Number guessing game: a free-running BCD counter supplies the secret, the player
// enters a DIGITS-digit guess one digit at a time and receives a Hi/Lo verdict.
//
// state  | meaning
// IDLE   | counter runs, "PLAY" shown, waiting for Ready to start a game
// ENTRY  | player edits guess digit Cursor (Iter) and confirms it (Ready)
// CMP    | single cycle: compare guess with secret, spend one guess on a miss
// RESULT | "Hi" or "Lo" shown, Ready starts the next guess
// WIN    | "YAY" shown, Ready returns to IDLE
// LOSE   | "LoSE" shown, Ready returns to IDLE
module guess_game_n #(
    parameter int DIGITS      = 4,
    parameter int MAX_GUESSES = 10
) (
    input  logic                clock,
    input  logic                Reset,
    input  logic                Ready,
    input  logic                Iter,
    output logic [7*DIGITS-1:0] Digits,
    output logic [2:0]          Cursor,
    output logic [3:0]          Remaining,
    output logic                Win,
    output logic                Lose
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_ENTRY,
        S_CMP,
        S_RESULT,
        S_WIN,
        S_LOSE
    } state_t;

    localparam logic [6:0] SEG_BLANK = 7'b1111111;
    localparam logic [6:0] SEG_H     = 7'b1001000;
    localparam logic [6:0] SEG_I     = 7'b1001111;
    localparam logic [6:0] SEG_L     = 7'b1110001;
    localparam logic [6:0] SEG_O     = 7'b1100010;
    localparam logic [6:0] SEG_Y     = 7'b1000100;
    localparam logic [6:0] SEG_A     = 7'b0001000;
    localparam logic [6:0] SEG_P     = 7'b0011000;
    localparam logic [6:0] SEG_S     = 7'b0100100;
    localparam logic [6:0] SEG_E     = 7'b0110000;

    localparam logic [2:0] CURSOR_TOP = 3'(DIGITS - 1);
    localparam logic [3:0] GUESS_BUDGET = 4'(MAX_GUESSES);

    state_t                    state;
    logic                      ready_q;
    logic                      iter_q;
    logic                      rdy_ev;
    logic                      itr_ev;
    logic [DIGITS-1:0][3:0]    counter;
    logic [DIGITS-1:0][3:0]    counter_next;
    logic [DIGITS-1:0][3:0]    secret;
    logic [DIGITS-1:0][3:0]    guess;
    logic                      guess_hi;
    logic                      carry;
    logic [3:0]                cur_digit;
    logic [3:0]                cur_digit_inc;
    logic [3:0]                remaining_dec;

    assign rdy_ev = Ready & ~ready_q;
    assign itr_ev = Iter & ~iter_q;

    function automatic logic [6:0] seg_num(input logic [3:0] d);
        case (d)
            4'd0:    seg_num = 7'b0000001;
            4'd1:    seg_num = 7'b1001111;
            4'd2:    seg_num = 7'b0010010;
            4'd3:    seg_num = 7'b0000110;
            4'd4:    seg_num = 7'b1001100;
            4'd5:    seg_num = 7'b0100100;
            4'd6:    seg_num = 7'b0100000;
            4'd7:    seg_num = 7'b0001111;
            4'd8:    seg_num = 7'b0000000;
            4'd9:    seg_num = 7'b0000100;
            default: seg_num = SEG_BLANK;
        endcase
    endfunction

    // BCD ripple increment: each digit wraps 9->0 and carries into the next
    always_comb begin
        counter_next = counter;
        carry        = 1'b1;
        for (int k = 0; k < DIGITS; k++) begin
            if (carry) begin
                if (counter[k] == 4'd9) begin
                    counter_next[k] = 4'd0;
                end else begin
                    counter_next[k] = counter[k] + 4'd1;
                    carry           = 1'b0;
                end
            end
        end
    end

    always_comb begin
        cur_digit = 4'd0;
        for (int k = 0; k < DIGITS; k++) begin
            if (Cursor == 3'(k)) begin
                cur_digit = guess[k];
            end
        end
        cur_digit_inc = (cur_digit == 4'd9) ? 4'd0 : cur_digit + 4'd1;
    end

    assign remaining_dec = Remaining - 4'd1;

    always_ff @(posedge clock) begin
        if (Reset) begin
            state     <= S_IDLE;
            ready_q   <= 1'b1;
            iter_q    <= 1'b1;
            counter   <= '0;
            secret    <= '0;
            guess     <= '0;
            guess_hi  <= 1'b0;
            Cursor    <= 3'd0;
            Remaining <= GUESS_BUDGET;
            Win       <= 1'b0;
            Lose      <= 1'b0;
        end else begin
            ready_q <= Ready;
            iter_q  <= Iter;
            if (state == S_IDLE) begin
                counter <= counter_next;
            end
            case (state)
                S_IDLE: begin
                    if (rdy_ev) begin
                        secret    <= counter;
                        guess     <= '0;
                        Cursor    <= CURSOR_TOP;
                        Remaining <= GUESS_BUDGET;
                        state     <= S_ENTRY;
                    end
                end
                S_ENTRY: begin
                    // increment lands on the current digit before the cursor moves
                    if (itr_ev) begin
                        for (int k = 0; k < DIGITS; k++) begin
                            if (Cursor == 3'(k)) begin
                                guess[k] <= cur_digit_inc;
                            end
                        end
                    end
                    if (rdy_ev) begin
                        if (Cursor == 3'd0) begin
                            state <= S_CMP;
                        end else begin
                            Cursor <= Cursor - 3'd1;
                        end
                    end
                end
                S_CMP: begin
                    if (guess == secret) begin
                        state <= S_WIN;
                        Win   <= 1'b1;
                    end else begin
                        // BCD digits order the same way as the packed binary vector
                        guess_hi  <= (guess > secret);
                        Remaining <= remaining_dec;
                        if (remaining_dec == 4'd0) begin
                            state <= S_LOSE;
                            Lose  <= 1'b1;
                        end else begin
                            state <= S_RESULT;
                        end
                    end
                end
                S_RESULT: begin
                    if (rdy_ev) begin
                        guess  <= '0;
                        Cursor <= CURSOR_TOP;
                        state  <= S_ENTRY;
                    end
                end
                S_WIN, S_LOSE: begin
                    if (rdy_ev) begin
                        Win   <= 1'b0;
                        Lose  <= 1'b0;
                        state <= S_IDLE;
                    end
                end
                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

    always_comb begin
        Digits = '1;
        case (state)
            S_IDLE: begin
                Digits[27:0] = {SEG_P, SEG_L, SEG_A, SEG_Y};
            end
            S_ENTRY, S_CMP: begin
                for (int k = 0; k < DIGITS; k++) begin
                    Digits[7*k +: 7] = seg_num(guess[k]);
                end
            end
            S_RESULT: begin
                Digits[13:0] = guess_hi ? {SEG_H, SEG_I} : {SEG_L, SEG_O};
            end
            S_WIN: begin
                Digits[20:0] = {SEG_Y, SEG_A, SEG_Y};
            end
            S_LOSE: begin
                Digits[27:0] = {SEG_L, SEG_O, SEG_S, SEG_E};
            end
            default: begin
                Digits = '1;
            end
        endcase
    end

endmodule

// File: tb/tb_guess_game_n.sv
// Directed bench for guess_game_n: a 4-digit/10-guess instance and a 5-digit/2-guess
// instance share one stimulus stream; each check targets the instance it concerns.
module tb_guess_game_n;

    logic        clock = 1'b0;
    logic        Reset = 1'b1;
    logic        Ready = 1'b0;
    logic        Iter  = 1'b0;
    logic [27:0] digits_a;
    logic [2:0]  cursor_a;
    logic [3:0]  remaining_a;
    logic        win_a;
    logic        lose_a;
    logic [34:0] digits_b;
    logic [2:0]  cursor_b;
    logic [3:0]  remaining_b;
    logic        win_b;
    logic        lose_b;

    int total  = 0;
    int passed = 0;

    localparam logic [6:0] BLK = 7'b1111111;
    localparam logic [6:0] SH  = 7'b1001000;
    localparam logic [6:0] SI  = 7'b1001111;
    localparam logic [6:0] SL  = 7'b1110001;
    localparam logic [6:0] SO  = 7'b1100010;
    localparam logic [6:0] SY  = 7'b1000100;
    localparam logic [6:0] SA  = 7'b0001000;
    localparam logic [6:0] SP  = 7'b0011000;
    localparam logic [6:0] SS  = 7'b0100100;
    localparam logic [6:0] SE  = 7'b0110000;

    typedef struct {
        logic        rdy;
        logic        itr;
        logic [2:0]  cur;
        logic [27:0] dig;
        logic [3:0]  rem;
    } step_t;

    step_t steps[$];

    guess_game_n #(.DIGITS(4), .MAX_GUESSES(10)) dut_a (
        .clock(clock), .Reset(Reset), .Ready(Ready), .Iter(Iter),
        .Digits(digits_a), .Cursor(cursor_a), .Remaining(remaining_a),
        .Win(win_a), .Lose(lose_a)
    );

    guess_game_n #(.DIGITS(5), .MAX_GUESSES(2)) dut_b (
        .clock(clock), .Reset(Reset), .Ready(Ready), .Iter(Iter),
        .Digits(digits_b), .Cursor(cursor_b), .Remaining(remaining_b),
        .Win(win_b), .Lose(lose_b)
    );

    always #5 clock = ~clock;

    function automatic logic [6:0] num(input int d);
        logic [6:0] tbl [10];
        tbl[0] = 7'b0000001; tbl[1] = 7'b1001111; tbl[2] = 7'b0010010;
        tbl[3] = 7'b0000110; tbl[4] = 7'b1001100; tbl[5] = 7'b0100100;
        tbl[6] = 7'b0100000; tbl[7] = 7'b0001111; tbl[8] = 7'b0000000;
        tbl[9] = 7'b0000100;
        return tbl[d];
    endfunction

    function automatic logic [27:0] n4(input int d3, input int d2, input int d1, input int d0);
        return {num(d3), num(d2), num(d1), num(d0)};
    endfunction

    function automatic void add(input logic r, input logic i, input logic [2:0] c,
                                input logic [27:0] d, input logic [3:0] m);
        step_t s;
        s.rdy = r; s.itr = i; s.cur = c; s.dig = d; s.rem = m;
        steps.push_back(s);
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end else begin
            passed++;
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic press(input logic r, input logic i);
        Ready = r;
        Iter  = i;
        tick();
        Ready = 1'b0;
        Iter  = 1'b0;
        tick();
    endtask

    // leaves the bench in cycle 0 after reset (counter value 0)
    task automatic do_reset();
        Reset = 1'b1;
        tick();
        Reset = 1'b0;
    endtask

    // rdy_ev lands in counter cycle n, so the secret becomes n
    task automatic start_game(input int n);
        do_reset();
        repeat (n) tick();
        press(1'b1, 1'b0);
    endtask

    initial begin
        // reset with Ready held high: no game start on release
        Ready = 1'b1;
        repeat (3) tick();
        Reset = 1'b0;
        repeat (3) tick();
        check("hold_idle_digits_a", digits_a, {SP, SL, SA, SY});
        check("hold_idle_digits_b", digits_b, {BLK, SP, SL, SA, SY});
        check("reset_cursor", cursor_a, 3'd0);
        check("reset_remaining_a", remaining_a, 4'd10);
        check("reset_remaining_b", remaining_b, 4'd2);
        check("reset_win_lose", {win_a, lose_a, win_b, lose_b}, 4'b0000);
        Ready = 1'b0;
        tick();
        check("hold_still_idle", digits_a, {SP, SL, SA, SY});

        // secret 0037, guessed right on the first try
        start_game(37);
        check("start_cursor_a", cursor_a, 3'd3);
        check("start_cursor_b", cursor_b, 3'd4);
        check("start_digits", digits_a, n4(0, 0, 0, 0));
        press(1'b1, 1'b0);
        press(1'b1, 1'b0);
        repeat (3) press(1'b0, 1'b1);
        press(1'b1, 1'b0);
        repeat (7) press(1'b0, 1'b1);
        check("entry_0037", digits_a, n4(0, 0, 3, 7));
        Ready = 1'b1;
        tick();
        Ready = 1'b0;
        check("cmp_win_low", win_a, 1'b0);
        tick();
        check("win_two_cycles", win_a, 1'b1);
        check("win_digits", digits_a, {BLK, SY, SA, SY});
        check("win_remaining", remaining_a, 4'd10);
        check("win_lose_low", lose_a, 1'b0);
        press(1'b1, 1'b0);
        check("win_to_idle", digits_a, {SP, SL, SA, SY});
        check("win_cleared", win_a, 1'b0);

        // table: Hi, Lo, same-cycle edges, digit wrap, all against secret 0037
        add(1, 0, 3'd2, n4(0, 0, 0, 0), 4'd10);
        add(1, 0, 3'd1, n4(0, 0, 0, 0), 4'd10);
        for (int i = 1; i <= 4; i++) add(0, 1, 3'd1, n4(0, 0, i, 0), 4'd10);
        add(1, 0, 3'd0, n4(0, 0, 4, 0), 4'd10);
        add(1, 0, 3'd0, {BLK, BLK, SH, SI}, 4'd9);
        add(1, 0, 3'd3, n4(0, 0, 0, 0), 4'd9);
        add(1, 0, 3'd2, n4(0, 0, 0, 0), 4'd9);
        add(1, 0, 3'd1, n4(0, 0, 0, 0), 4'd9);
        add(0, 1, 3'd1, n4(0, 0, 1, 0), 4'd9);
        add(1, 0, 3'd0, n4(0, 0, 1, 0), 4'd9);
        add(0, 1, 3'd0, n4(0, 0, 1, 1), 4'd9);
        add(0, 1, 3'd0, n4(0, 0, 1, 2), 4'd9);
        add(1, 0, 3'd0, {BLK, BLK, SL, SO}, 4'd8);
        add(1, 0, 3'd3, n4(0, 0, 0, 0), 4'd8);
        add(1, 1, 3'd2, n4(1, 0, 0, 0), 4'd8);
        for (int i = 1; i <= 11; i++) add(0, 1, 3'd2, n4(1, i % 10, 0, 0), 4'd8);
        add(1, 0, 3'd1, n4(1, 1, 0, 0), 4'd8);

        start_game(37);
        foreach (steps[s]) begin
            press(steps[s].rdy, steps[s].itr);
            check($sformatf("step%0d_cursor", s), cursor_a, steps[s].cur);
            check($sformatf("step%0d_digits", s), digits_a, steps[s].dig);
            check($sformatf("step%0d_remaining", s), remaining_a, steps[s].rem);
        end

        // reset in ENTRY with cursor 1
        Reset = 1'b1;
        tick();
        check("midreset_digits", digits_a, {SP, SL, SA, SY});
        check("midreset_cursor", cursor_a, 3'd0);
        check("midreset_remaining", remaining_a, 4'd10);
        Reset = 1'b0;
        repeat (1) tick();
        press(1'b1, 1'b0);
        check("restart_digits", digits_a, n4(0, 0, 0, 0));
        // a long Ready hold moves the cursor once
        Ready = 1'b1;
        repeat (5) tick();
        Ready = 1'b0;
        tick();
        check("hold_counts_once", cursor_a, 3'd2);
        press(1'b1, 1'b0);
        press(1'b1, 1'b0);
        press(1'b0, 1'b1);
        check("entry_0001", digits_a, n4(0, 0, 0, 1));
        press(1'b1, 1'b0);
        check("counter_cleared_win", win_a, 1'b1);

        // 5-digit, 2-guess instance: secret 00001, two misses
        start_game(1);
        check("b_start_remaining", remaining_b, 4'd2);
        repeat (5) press(1'b1, 1'b0);
        check("b_lo_digits", digits_b, {BLK, BLK, BLK, SL, SO});
        check("b_lo_remaining", remaining_b, 4'd1);
        press(1'b1, 1'b0);
        check("b_reentry_cursor", cursor_b, 3'd4);
        repeat (5) press(1'b1, 1'b0);
        check("b_lose", lose_b, 1'b1);
        check("b_lose_digits", digits_b, {BLK, SL, SO, SS, SE});
        check("b_lose_remaining", remaining_b, 4'd0);
        press(1'b1, 1'b0);
        check("b_lose_to_idle", digits_b, {BLK, SP, SL, SA, SY});
        check("b_lose_cleared", lose_b, 1'b0);
        // counter held at 2 during the game, 3 now, 8 after five more cycles
        repeat (5) tick();
        press(1'b1, 1'b0);
        check("b_new_remaining", remaining_b, 4'd2);
        repeat (4) press(1'b1, 1'b0);
        repeat (8) press(1'b0, 1'b1);
        check("b_entry_8", digits_b[6:0], num(8));
        press(1'b1, 1'b0);
        check("b_counter_resumed_win", win_b, 1'b1);
        check("b_win_digits", digits_b, {BLK, BLK, SY, SA, SY});

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
